hardware_result_tap: RTL and testbench

Parametrised result tap between the reduction machine's wide state word and the host side. It monitors a flag bit of the state word, extracts a configurable result field, and buffers captured results in a small FIFO behind a valid/ready stream. It keeps the most recent result on a hold register and counts results dropped on overflow. It replaces the fixed 33-bit slice on the top entity with a buffered, handshaked path of arbitrary width and depth.

---
 rtl/hardware_result_tap_if.sv | 8 +
 rtl/hardware_result_tap.sv | 78 +++++++
 tb/tb_hardware_result_tap.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hardware_result_tap_if.sv
// hardware_result_tap_if: valid/ready result stream between the tap and its consumer.
interface hardware_result_tap_if #(parameter int W = 33) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/hardware_result_tap.sv
// hardware_result_tap: flag-triggered capture of a state-word field into a valid/ready FIFO,
// with a last-value hold register and a saturating drop counter.
module hardware_result_tap #(
    parameter int STATE_W      = 130,
    parameter int FLAG_BIT     = 0,
    parameter int FIELD_LO     = 1,
    parameter int FIELD_W      = 33,
    parameter int DEPTH        = 4,
    parameter int CAPTURE_MODE = 0,
    parameter int CNT_W        = 8
) (
    input  logic                     system1000,
    input  logic                     system1000_rst,
    input  logic [STATE_W-1:0]       state_i,
    hardware_result_tap_if.master    res,
    output logic [FIELD_W-1:0]       last_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    input  logic                     clear_i
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [FIELD_W-1:0] mem_q [DEPTH];
    logic [FIELD_W-1:0] mem_d [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [FIELD_W-1:0] last_q, last_d, field;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic flag_q, flag_d, overflow_q, overflow_d;
    logic flag, capture, full, empty, pop, push, drop;
    logic unused_state;
    assign unused_state = ^state_i;
    always_comb begin
        flag       = state_i[FLAG_BIT];
        field      = state_i[FIELD_LO +: FIELD_W];
        capture    = (CAPTURE_MODE != 0) ? flag : (flag && !flag_q);
        empty      = wr_q == rd_q;
        full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop        = !empty && res.ready;
        push       = capture && (!full || pop);
        drop       = capture && full && !pop;
        wr_d       = push ? wr_q + PTR_ONE : wr_q;
        rd_d       = pop ? rd_q + PTR_ONE : rd_q;
        last_d     = capture ? field : last_q;
        flag_d     = flag;
        // clear wins over a drop in the same cycle, so that drop is never counted
        overflow_d = !clear_i && (overflow_q || drop);
        cnt_d      = clear_i ? '0 : (drop && cnt_q != '1) ? cnt_q + CNT_ONE : cnt_q;
        mem_d      = mem_q;
        if (push) mem_d[wr_q[AW-1:0]] = field;
    end
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            mem_q      <= '{default: '0};
            wr_q       <= '0;
            rd_q       <= '0;
            last_q     <= '0;
            cnt_q      <= '0;
            flag_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            flag_q     <= flag_d;
            overflow_q <= overflow_d;
        end
    end
    assign res.valid  = !empty;
    assign res.data   = mem_q[rd_q[AW-1:0]];
    assign level_o    = wr_q - rd_q;
    assign last_o     = last_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = cnt_q;
endmodule

// File: tb/tb_hardware_result_tap.sv
// tb_hardware_result_tap: directed scenarios plus randomized traffic against a queue-based model.
module tb_hardware_result_tap;
    localparam int SW = 130, FW = 33, D = 4;
    logic clk = 1'b0, rst = 1'b1, clr0 = 1'b0, clr1 = 1'b0;
    logic [SW-1:0] st0 = '0, st1 = '0;
    logic [FW-1:0] last0, last1;
    logic [2:0] lvl0, lvl1;
    logic ov0, ov1;
    logic [7:0] dc0;
    logic [1:0] dc1;
    int n_chk = 0, n_pass = 0;
    logic [FW-1:0] mq[$];
    logic [FW-1:0] m_last;
    logic m_ov, m_fp;
    int m_cnt;

    hardware_result_tap_if #(.W(FW)) b0 ();
    hardware_result_tap_if #(.W(FW)) b1 ();

    hardware_result_tap u0 (.system1000(clk), .system1000_rst(rst), .state_i(st0), .res(b0),
        .last_o(last0), .level_o(lvl0), .overflow_o(ov0), .drop_cnt_o(dc0), .clear_i(clr0));
    hardware_result_tap #(.CAPTURE_MODE(1), .CNT_W(2)) u1 (.system1000(clk), .system1000_rst(rst),
        .state_i(st1), .res(b1), .last_o(last1), .level_o(lvl1), .overflow_o(ov1), .drop_cnt_o(dc1),
        .clear_i(clr1));

    always #5 clk = ~clk;

    task automatic m_reset();
        mq.delete();
        m_last = '0; m_ov = 1'b0; m_cnt = 0; m_fp = 1'b0;
    endtask

    // Behavioural model of u0: a bounded queue with mode-0 edge capture
    task automatic m_step(input logic f, input logic [FW-1:0] d, input logic rdy, input logic clr);
        logic cap;
        cap = f && !m_fp;
        m_fp = f;
        if (rdy && mq.size() != 0) void'(mq.pop_front());
        if (cap) begin
            m_last = d;
            if (mq.size() < D) mq.push_back(d);
            else if (!clr) begin
                m_ov = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        if (clr) begin m_ov = 1'b0; m_cnt = 0; end
    endtask

    task automatic cyc(input logic f, input logic [FW-1:0] d, input logic rdy, input logic clr);
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        st0 = r[SW-1:0];
        st0[FW:1] = d;
        st0[0] = f;
        b0.ready = rdy;
        clr0 = clr;
        m_step(f, d, rdy, clr);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        st0 = '0; st0[FW:1] = 33'd7; st0[0] = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (b0.valid !== 1'b0 || lvl0 !== 3'd0) $display("FAIL reset_hold valid=%0b level=%0d want 0/0", b0.valid, lvl0); else n_pass++;
        rst = 1'b0;
        m_reset();
        n_chk++; if (b0.valid !== 1'b0 || b0.data !== '0 || last0 !== '0 || ov0 !== 1'b0 || dc0 !== 8'd0) $display("FAIL reset_state valid=%0b data=%0h last=%0h ov=%0b drop=%0d want all 0", b0.valid, b0.data, last0, ov0, dc0); else n_pass++;
        cyc(1'b1, 33'd7, 1'b0, 1'b0);
        n_chk++; if (b0.valid !== 1'b1 || lvl0 !== 3'd1 || b0.data !== 33'd7) $display("FAIL reset_first_capture valid=%0b level=%0d data=%0h want 1/1/7", b0.valid, lvl0, b0.data); else n_pass++;
        cyc(1'b1, 33'd7, 1'b0, 1'b0);
        n_chk++; if (lvl0 !== 3'd1) $display("FAIL reset_no_second_capture level=%0d want 1", lvl0); else n_pass++;
        cyc(1'b0, 33'd0, 1'b1, 1'b0);
        n_chk++; if (lvl0 !== 3'd0 || b0.valid !== 1'b0) $display("FAIL reset_drain level=%0d valid=%0b want 0/0", lvl0, b0.valid); else n_pass++;
    endtask

    task automatic test_single();
        cyc(1'b1, 33'h1_2345_6789, 1'b0, 1'b0);
        n_chk++; if (b0.valid !== 1'b1 || b0.data !== 33'h1_2345_6789 || last0 !== 33'h1_2345_6789) $display("FAIL single_capture valid=%0b data=%0h last=%0h want 1/123456789/123456789", b0.valid, b0.data, last0); else n_pass++;
        cyc(1'b0, 33'd0, 1'b1, 1'b0);
        n_chk++; if (b0.valid !== 1'b0) $display("FAIL single_pop valid=%0b want 0", b0.valid); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, FW'(i), 1'b0, 1'b0);
            cyc(1'b0, 33'd0, 1'b0, 1'b0);
        end
        n_chk++; if (lvl0 !== 3'd4 || ov0 !== 1'b1 || dc0 !== 8'd2 || last0 !== 33'd6) $display("FAIL overflow_state level=%0d ov=%0b drop=%0d last=%0d want 4/1/2/6", lvl0, ov0, dc0, last0); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            n_chk++; if (b0.valid !== 1'b1 || b0.data !== FW'(i)) $display("FAIL overflow_drain[%0d] valid=%0b data=%0d want 1/%0d", i, b0.valid, b0.data, i); else n_pass++;
            cyc(1'b0, 33'd0, 1'b1, 1'b0);
        end
        n_chk++; if (b0.valid !== 1'b0 || ov0 !== 1'b1) $display("FAIL overflow_empty valid=%0b ov=%0b want 0/1", b0.valid, ov0); else n_pass++;
        cyc(1'b0, 33'd0, 1'b0, 1'b1);
        n_chk++; if (ov0 !== 1'b0 || dc0 !== 8'd0) $display("FAIL overflow_clear ov=%0b drop=%0d want 0/0", ov0, dc0); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, FW'(i), 1'b0, 1'b0);
            cyc(1'b0, 33'd0, 1'b0, 1'b0);
        end
        cyc(1'b1, 33'd5, 1'b1, 1'b0);
        n_chk++; if (lvl0 !== 3'd4 || ov0 !== 1'b0 || dc0 !== 8'd0 || last0 !== 33'd5) $display("FAIL full_push_pop level=%0d ov=%0b drop=%0d last=%0d want 4/0/0/5", lvl0, ov0, dc0, last0); else n_pass++;
        for (int i = 2; i <= 5; i++) begin
            n_chk++; if (b0.valid !== 1'b1 || b0.data !== FW'(i)) $display("FAIL full_drain[%0d] valid=%0b data=%0d want 1/%0d", i, b0.valid, b0.data, i); else n_pass++;
            cyc(1'b0, 33'd0, 1'b1, 1'b0);
        end
        n_chk++; if (lvl0 !== 3'd0) $display("FAIL full_drain_empty level=%0d want 0", lvl0); else n_pass++;
    endtask

    task automatic test_mode1();
        b1.ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            st1 = '0; st1[0] = 1'b1; st1[FW:1] = FW'(k + 1);
            cyc(1'b0, 33'd0, 1'b0, 1'b0);
        end
        n_chk++; if (lvl1 !== 3'd4 || dc1 !== 2'd3 || ov1 !== 1'b1 || last1 !== 33'd10 || b1.data !== 33'd1) $display("FAIL mode1_saturate level=%0d drop=%0d ov=%0b last=%0d head=%0d want 4/3/1/10/1", lvl1, dc1, ov1, last1, b1.data); else n_pass++;
        st1[FW:1] = 33'd11;
        clr1 = 1'b1;
        cyc(1'b0, 33'd0, 1'b0, 1'b0);
        clr1 = 1'b0;
        n_chk++; if (dc1 !== 2'd0 || ov1 !== 1'b0 || lvl1 !== 3'd4 || last1 !== 33'd11) $display("FAIL mode1_clear drop=%0d ov=%0b level=%0d last=%0d want 0/0/4/11", dc1, ov1, lvl1, last1); else n_pass++;
        st1[0] = 1'b0;
        cyc(1'b0, 33'd0, 1'b0, 1'b0);
        n_chk++; if (dc1 !== 2'd0 || ov1 !== 1'b0) $display("FAIL mode1_idle drop=%0d ov=%0b want 0/0", dc1, ov1); else n_pass++;
    endtask

    task automatic test_wrap();
        cyc(1'b1, 33'd1000, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 33'd0, 1'b0, 1'b0);
            n_chk++; if (b0.data !== FW'(999 + i) || lvl0 !== 3'd1) $display("FAIL wrap_head[%0d] data=%0d level=%0d want %0d/1", i, b0.data, lvl0, 999 + i); else n_pass++;
            cyc(1'b1, FW'(1000 + i), 1'b1, 1'b0);
            n_chk++; if (lvl0 !== 3'd1) $display("FAIL wrap_level[%0d] level=%0d want 1", i, lvl0); else n_pass++;
        end
        n_chk++; if (b0.data !== 33'd1020) $display("FAIL wrap_last data=%0d want 1020", b0.data); else n_pass++;
        cyc(1'b0, 33'd0, 1'b1, 1'b0);
        n_chk++; if (lvl0 !== 3'd0 || b0.valid !== 1'b0) $display("FAIL wrap_empty level=%0d valid=%0b want 0/0", lvl0, b0.valid); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), FW'({$urandom, $urandom}), $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0);
            n_chk++; if (b0.valid !== (mq.size() != 0) || lvl0 !== 3'(mq.size())) $display("FAIL rand_level[%0d] valid=%0b level=%0d want %0d", i, b0.valid, lvl0, mq.size()); else n_pass++;
            if (mq.size() != 0) begin
                n_chk++; if (b0.data !== mq[0]) $display("FAIL rand_head[%0d] data=%0h want %0h", i, b0.data, mq[0]); else n_pass++;
            end
            n_chk++; if (last0 !== m_last || ov0 !== m_ov || dc0 !== 8'(m_cnt)) $display("FAIL rand_status[%0d] last=%0h ov=%0b drop=%0d want %0h/%0b/%0d", i, last0, ov0, dc0, m_last, m_ov, m_cnt); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, FW'(50 + i), 1'b0, 1'b0);
            cyc(1'b0, 33'd0, 1'b0, 1'b0);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++; if (b0.valid !== 1'b0 || lvl0 !== 3'd0 || last0 !== '0 || ov0 !== 1'b0 || dc0 !== 8'd0) $display("FAIL async_reset valid=%0b level=%0d last=%0h ov=%0b drop=%0d want all 0", b0.valid, lvl0, last0, ov0, dc0); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
        cyc(1'b0, 33'd0, 1'b1, 1'b0);
        n_chk++; if (b0.valid !== 1'b0 || lvl0 !== 3'd0) $display("FAIL async_reset_after valid=%0b level=%0d want 0/0", b0.valid, lvl0); else n_pass++;
    endtask

    initial begin
        b0.ready = 1'b0;
        b1.ready = 1'b0;
        m_reset();
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_mode1();
        test_wrap();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
